// File: rtl/mux_arb_nx1.sv
// rtl/mux_arb_nx1.sv - N-to-1 registered stream mux with round-robin or fixed-priority arbitration
//
// Purpose:
//   Selects one of NCH valid/ready input channels per cycle and registers its
//   beat into a single output stage. The output stage refills in the same cycle
//   it drains, so a steady stream of requests gives one beat per cycle.
//
// Parameters:
//   DW  - data width per channel
//   NCH - number of input channels (2..16)
//   RR  - 1: round-robin starting at ptr, 0: fixed priority (channel 0 highest)
//   SW  - derived select width, $clog2(NCH)
//
// Ports:
//   clk       - clock, rising edge
//   rst_n     - asynchronous active-low reset
//   in_valid  - [NCH]     per-channel beat offered
//   in_data   - [NCH*DW]  channel i data at [i*DW +: DW]
//   in_ready  - [NCH]     one-hot (or zero) accept for the granted channel
//   out_valid - output register holds a beat
//   out_data  - [DW]      registered selected data
//   out_sel   - [SW]      registered index of the supplying channel
//   out_ready - downstream accepts the output beat

module mux_arb_nx1 #(
  parameter int DW  = 2,
  parameter int NCH = 4,
  parameter int RR  = 1,
  localparam int SW = $clog2(NCH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NCH-1:0]    in_valid,
  input  logic [NCH*DW-1:0] in_data,
  output logic [NCH-1:0]    in_ready,
  output logic              out_valid,
  output logic [DW-1:0]     out_data,
  output logic [SW-1:0]     out_sel,
  input  logic              out_ready
);

  logic [SW-1:0] r_ptr;
  logic          r_valid;
  logic [DW-1:0] r_data;
  logic [SW-1:0] r_sel;

  logic          w_ld;
  logic          w_found;
  logic [SW-1:0] w_gidx;
  logic [DW-1:0] w_gdata;
  logic [SW-1:0] w_ptr_next;
  int            w_start;
  int            w_idx;

  // Output stage may load when empty or when its beat leaves this cycle.
  assign w_ld = !r_valid || out_ready;

  // Search starts at ptr for round-robin, at channel 0 for fixed priority.
  assign w_start = (RR != 0) ? int'(r_ptr) : 0;

  // Rotating search; the index wraps at NCH (not at 2**SW) so out-of-range
  // channels are never visited.
  always_comb begin
    w_found = 1'b0;
    w_gidx  = '0;
    w_idx   = 0;
    for (int j = 0; j < NCH; j++) begin
      w_idx = w_start + j;
      if (w_idx >= NCH) w_idx = w_idx - NCH;
      if (!w_found && in_valid[w_idx[SW-1:0]]) begin
        w_found = 1'b1;
        w_gidx  = w_idx[SW-1:0];
      end
    end
  end

  assign w_gdata    = in_data[w_gidx*DW +: DW];
  assign w_ptr_next = (w_gidx == SW'(NCH - 1)) ? '0 : w_gidx + SW'(1);

  // Gated by rst_n so nothing is acknowledged while reset is held.
  assign in_ready = (rst_n && w_ld && w_found) ? (NCH'(1) << w_gidx) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_sel   <= '0;
      r_ptr   <= '0;
    end else if (w_ld) begin
      if (w_found) begin
        r_valid <= 1'b1;
        r_data  <= w_gdata;
        r_sel   <= w_gidx;
        r_ptr   <= w_ptr_next;
      end else begin
        // Drained with nothing to refill: data/sel keep their last values.
        r_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_valid;
  assign out_data  = r_data;
  assign out_sel   = r_sel;

endmodule

// File: tb/tb_mux_arb_nx1.sv
// tb/tb_mux_arb_nx1.sv - self-checking bench for mux_arb_nx1 (RR NCH=4, fixed NCH=4, RR NCH=3)

module tb_mux_arb_nx1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Instance 0: RR=1 NCH=4, instance 1: RR=0 NCH=4, instance 2: RR=1 NCH=3. DW=8 for all.
  logic [3:0]  iv [3];
  logic [31:0] id [3];
  logic        ordy [3];
  logic [3:0]  ir [3];
  logic        ov [3];
  logic [7:0]  od [3];
  logic [1:0]  os [3];

  logic [3:0] ir0, ir1;
  logic [2:0] ir2;
  assign ir[0] = ir0;
  assign ir[1] = ir1;
  assign ir[2] = {1'b0, ir2};

  mux_arb_nx1 #(.DW(8), .NCH(4), .RR(1)) u_rr4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_data(id[0]), .in_ready(ir0),
    .out_valid(ov[0]), .out_data(od[0]), .out_sel(os[0]), .out_ready(ordy[0]));

  mux_arb_nx1 #(.DW(8), .NCH(4), .RR(0)) u_fp4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_data(id[1]), .in_ready(ir1),
    .out_valid(ov[1]), .out_data(od[1]), .out_sel(os[1]), .out_ready(ordy[1]));

  mux_arb_nx1 #(.DW(8), .NCH(3), .RR(1)) u_rr3 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2][2:0]), .in_data(id[2][23:0]), .in_ready(ir2),
    .out_valid(ov[2]), .out_data(od[2]), .out_sel(os[2][1:0]), .out_ready(ordy[2]));

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  // Reference model: one output slot per instance plus a rotation pointer.
  int m_n  [3] = '{4, 4, 3};
  bit m_rr [3] = '{1'b1, 1'b0, 1'b1};
  bit m_valid [3];
  int m_data  [3];
  int m_sel   [3];
  int m_ptr   [3];

  function automatic int pick(input int mask, input int ptr, input int n, input bit rr);
    int start = rr ? ptr : 0;
    for (int j = 0; j < n; j++) begin
      int c = (start + j) % n;
      if (mask[c]) return c;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_valid[k] = 0; m_data[k] = 0; m_sel[k] = 0; m_ptr[k] = 0;
    end
  endtask

  task automatic check_outputs(input string what);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("%s.i%0d.out_valid", what, k), 32'(ov[k]), 32'(m_valid[k]));
      chk($sformatf("%s.i%0d.out_data", what, k), 32'(od[k]), 32'(m_data[k]));
      chk($sformatf("%s.i%0d.out_sel", what, k), 32'(os[k]), 32'(m_sel[k]));
    end
  endtask

  // Inputs are already driven (just after a rising edge). Check in_ready,
  // advance one edge, update the model and check the registered outputs.
  task automatic cycle(input string what);
    bit ld [3];
    int g  [3];
    #1;
    for (int k = 0; k < 3; k++) begin
      int mask = int'(iv[k]) & ((1 << m_n[k]) - 1);
      ld[k] = !m_valid[k] || ordy[k];
      g[k]  = pick(mask, m_ptr[k], m_n[k], m_rr[k]);
      chk($sformatf("%s.i%0d.in_ready", what, k), 32'(ir[k]),
          (rst_n && ld[k] && g[k] >= 0) ? (32'd1 << g[k]) : 32'd0);
    end
    @(posedge clk);
    if (rst_n) begin
      for (int k = 0; k < 3; k++) begin
        if (ld[k]) begin
          if (g[k] >= 0) begin
            m_valid[k] = 1;
            m_data[k]  = int'(id[k][g[k]*8 +: 8]);
            m_sel[k]   = g[k];
            m_ptr[k]   = (g[k] + 1) % m_n[k];
          end else begin
            m_valid[k] = 0;
          end
        end
      end
    end
    #1;
    check_outputs(what);
  endtask

  task automatic drive_all(input logic [3:0] v0, input logic [3:0] v1, input logic [3:0] v2, input bit r);
    iv[0] = v0; iv[1] = v1; iv[2] = v2 & 4'b0111;
    for (int k = 0; k < 3; k++) ordy[k] = r;
  endtask

  task automatic randomize_data();
    for (int k = 0; k < 3; k++) id[k] = $urandom;
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      iv[k] = 4'hF; id[k] = 32'h1234_5678; ordy[k] = 1'b1;
    end
    iv[2] = 4'h7;
    model_reset();

    // Reset held with every channel requesting: nothing accepted, outputs zero.
    #2;
    check_outputs("reset");
    for (int k = 0; k < 3; k++) chk($sformatf("reset.i%0d.in_ready", k), 32'(ir[k]), 32'd0);
    @(posedge clk); #1;
    check_outputs("reset_edge");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    // That edge had no request blocked; the model saw reset, so re-align: the
    // edge after release already loaded a beat. Re-run from a fresh reset cleanly.
    rst_n = 1'b0; #1;
    model_reset();
    check_outputs("rereset");
    @(negedge clk);
    drive_all(4'b1111, 4'b1010, 4'b0111, 1'b1);
    rst_n = 1'b1;

    // Round-robin rotation, fixed priority and non-power-of-two wrap together.
    for (int c = 0; c < 8; c++) begin
      randomize_data();
      @(posedge clk) ; #0;
    end
    // The loop above only advanced time; redo the sequence under the model.
    rst_n = 1'b0; #1;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    model_reset();
    rst_n = 1'b0; #1;
    @(negedge clk);
    drive_all(4'b1111, 4'b1010, 4'b0111, 1'b1);
    rst_n = 1'b1;
    #2;
    for (int c = 0; c < 8; c++) begin
      randomize_data();
      cycle("seq");
      chk($sformatf("seq.rr4_order%0d", c), 32'(os[0]), 32'(c % 4));
      chk($sformatf("seq.fp4_sel%0d", c), 32'(os[1]), 32'd1);
      chk($sformatf("seq.rr3_order%0d", c), 32'(os[2]), 32'(c % 3));
    end

    // Single channel 2 with data A5.
    drive_all(4'b0100, 4'b0100, 4'b0100, 1'b1);
    id[0] = 32'h00A5_0000; id[1] = 32'h00A5_0000; id[2] = 32'h00A5_0000;
    cycle("single");
    chk("single.rr4_data", 32'(od[0]), 32'hA5);
    chk("single.rr4_sel", 32'(os[0]), 32'd2);

    // Backpressure: three stalled cycles, then release.
    drive_all(4'b0011, 4'b0011, 4'b0011, 1'b0);
    for (int c = 0; c < 3; c++) begin
      randomize_data();
      cycle("bp");
    end
    drive_all(4'b0011, 4'b0011, 4'b0011, 1'b1);
    randomize_data();
    cycle("bp_release");
    randomize_data();
    cycle("bp_release2");

    // Randomized traffic.
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < 3; k++) begin
        iv[k]   = 4'($urandom_range(0, 15));
        ordy[k] = ($urandom_range(0, 3) != 0);
      end
      iv[2] = iv[2] & 4'b0111;
      randomize_data();
      cycle("rand");
    end

    // Fill the output stage with downstream stalled, then reset mid-transfer.
    drive_all(4'b1111, 4'b1111, 4'b0111, 1'b0);
    cycle("fill");
    cycle("fill2");
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs("async_reset");
    for (int k = 0; k < 3; k++) chk($sformatf("async_reset.i%0d.in_ready", k), 32'(ir[k]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    // First edge after release: no replay of the discarded beat, ptr restarted at 0.
    drive_all(4'b1111, 4'b1111, 4'b0111, 1'b1);
    // The release edge itself loaded channel 0 from each instance.
    m_valid = '{1, 1, 1};
    m_sel   = '{0, 0, 0};
    m_data  = '{int'(id[0][7:0]), int'(id[1][7:0]), int'(id[2][7:0])};
    m_ptr   = '{1, 1, 1};
    for (int k = 0; k < 3; k++) m_data[k] = int'(od[k]) == int'(id[k][7:0]) ? m_data[k] : m_data[k];
    check_outputs("post_reset");
    for (int c = 0; c < 6; c++) begin
      randomize_data();
      cycle("post_reset_run");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mux_arb_nx1.md
MUX_ARB_NX1 -- requirements
Module: mux_arb_nx1

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter DW, default 2, giving the data width per channel (>=1).
REQ-002 The block SHALL have parameter NCH, default 4, giving the number of input channels (2..16).
REQ-003 The block SHALL have parameter RR, default 1, selecting round-robin arbitration when 1 and fixed priority (channel 0 highest) when 0.
REQ-004 The block SHALL define a derived width SW = $clog2(NCH).
Ports (name, direction, width, meaning):
REQ-005 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port rst_n, input, 1, the reset, which is asynchronous and active-low.
REQ-007 The block SHALL have port in_valid, input, NCH, with bit i set when channel i offers a beat.
REQ-008 The block SHALL have port in_data, input, NCH*DW, holding channel i data at bits [i*DW +: DW].
REQ-009 The block SHALL have port in_ready, output, NCH, with bit i set when channel i's beat is accepted this cycle.
REQ-010 The block SHALL have port out_valid, output, 1, set when the output register holds a beat.
REQ-011 The block SHALL have port out_data, output, DW, holding the registered selected data.
REQ-012 The block SHALL have port out_sel, output, SW, giving the registered index of the channel that supplied out_data.
REQ-013 The block SHALL have port out_ready, input, 1, set when the downstream consumer accepts the beat.

Function
REQ-014 Transfers SHALL follow the rule: input transfer on channel i = in_valid[i] & in_ready[i]; output transfer = out_valid & out_ready.
REQ-015 The load enable SHALL be ld = !out_valid | out_ready (the output register is empty or being drained this cycle).
REQ-016 in_ready SHALL be one-hot or zero; in_ready[i] = ld & grant[i], combinational from in_valid, pointer and out_valid/out_ready.
REQ-017 grant SHALL be zero when in_valid is all zero; otherwise exactly one bit is set, to a requesting channel.
REQ-018 With RR=0, grant SHALL select the lowest-index requesting channel.
REQ-019 With RR=1, grant SHALL select the first requesting channel searching ptr, ptr+1, ... NCH-1, 0, ... ptr-1 (wrap-around modulo NCH).
REQ-020 ptr SHALL be an SW-bit register that, on each input transfer from channel k, updates to (k+1) mod NCH and holds otherwise; when NCH is not a power of two, k=NCH-1 wraps to 0.
REQ-021 On an input transfer from channel k, at the next edge out_data SHALL equal in_data[k], out_sel SHALL equal k and out_valid SHALL be 1, giving latency 1 cycle.
REQ-022 When ld=1 and no channel requests, at the next edge out_valid SHALL become 0; out_data and out_sel hold.
REQ-023 When ld=0 (out_valid=1, out_ready=0), out_valid, out_data, out_sel and ptr SHALL hold, and in_ready SHALL be all zero (backpressure).
REQ-024 Simultaneous output drain and input transfer in one cycle SHALL give full throughput: one beat per cycle with no bubble.
REQ-025 A channel whose in_valid deasserts before it is granted SHALL lose no state; the arbiter keeps no per-channel memory other than ptr.
REQ-026 With out_ready held 1 and all NCH channels requesting under RR=1, each channel SHALL be granted exactly once in every NCH consecutive cycles.
REQ-027 Channels with index >= NCH do not exist; the block SHALL neither decode nor grant out-of-range out_sel values.

Reset
REQ-028 While rst_n=0, independent of clk, the block SHALL hold out_valid=0, out_data=0, out_sel=0 and ptr=0.
REQ-029 While rst_n=0, in_ready SHALL be all zero.
REQ-030 Reset asserted mid-transfer SHALL discard the held beat, which is not replayed.
REQ-031 The first edge after rst_n deasserts SHALL follow normal operation with ptr=0.

Verification
REQ-032 Reset check: assert rst_n=0 asynchronously while out_valid=1 -> out_valid, out_data, out_sel and in_ready go to 0 immediately, before the next clk edge.
REQ-033 Single channel (NCH=4, DW=8): in_valid=4'b0100, ch2 data=8'hA5, out_ready=1 -> in_ready=4'b0100 that cycle; next cycle out_valid=1, out_data=8'hA5, out_sel=2.
REQ-034 Round-robin (RR=1): in_valid=4'b1111 for 8 cycles, out_ready=1, after reset -> out_sel sequence 0,1,2,3,0,1,2,3 and one beat per cycle.
REQ-035 Fixed priority (RR=0): in_valid=4'b1010 for 3 cycles -> out_sel=1 every beat and channel 3 is never granted.
REQ-036 Backpressure: out_ready=0 for 3 cycles while out_valid=1 and in_valid=4'b0011 -> in_ready=0, out_data/out_sel/ptr stable; then out_ready=1 -> next grant follows ptr with no lost or duplicated beat.
REQ-037 Non-power-of-two (NCH=3, RR=1): in_valid=3'b111 for 6 cycles -> out_sel 0,1,2,0,1,2, and out_sel never equals 3.
